// File: rtl/uart_rx_fifo.sv
// UART receiver with sticky error flags
// and a first-word fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 43,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        RX,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rdy,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] C_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST =
    BW'(DATA_BITS - 1);
  localparam logic [AW:0] DEPTH =
    (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tick;
  logic                 push, set_fe, set_pe;
  logic                 pop, full, wr, ovf;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;

  assign rx   = sync_q[1];
  assign tick = (cnt_q == C_LAST);

  // Two-flop synchronizer, idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], RX};
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
    end
  end

  // Next state, bit sampling and frame verdict.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    push    = 1'b0;
    set_fe  = 1'b0;
    set_pe  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        par_d = 1'b0;
        if (!rx) state_d = START;
      end
      START: begin
        if (cnt_q == C_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = '0;
          sh_d  = {rx, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + BW'(1);
          if (bit_q == B_LAST)
            state_d = (PARITY_EN != 0) ?
                      PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          par_d   = rx ^ (^sh_q) ^
                    (PARITY_ODD != 0);
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (!rx) begin
            set_fe  = 1'b1;
            state_d = BREAK;
          end else if (par_q) begin
            set_pe  = 1'b1;
            state_d = IDLE;
          end else begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop  = rd_en & rdy;
  assign full = (count == DEPTH);
  assign wr   = push & (~full | pop);
  assign ovf  = push & full & ~pop;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr & ~pop)
        count <= count + (AW+1)'(1);
      else if (pop & ~wr)
        count <= count - (AW+1)'(1);
    end
  end

  // FIFO storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= sh_q;
  end

  assign rdy     = (count != '0);
  assign rx_data = mem[rd_ptr];

  // Sticky flags; a set beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (set_fe)       frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (set_pe)       parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (ovf)          overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule
